// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_tx_pkg;

   localparam int UART_BYTE_W          = 8;
   localparam int DEFAULT_DEPTH        = 16;
   localparam int DEFAULT_BUSY_TIMEOUT = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_RISE = 2'd2,
      WAIT_FALL = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Byte stream in, launch port out: the handshake signals around the feeder.
// master = stream source / transmitter model side, slave = feeder side.
interface uart_tx_feeder_if;
   import uart_tx_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [UART_BYTE_W-1:0] in_data;
   logic                   uart_start;
   logic [UART_BYTE_W-1:0] uart_data;
   logic                   uart_busy;

   modport master (
      output in_valid, in_data, uart_busy,
      input  in_ready, uart_start, uart_data
   );

   modport slave (
      input  in_valid, in_data, uart_busy,
      output in_ready, uart_start, uart_data
   );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous FIFO with registered storage. Pointers carry one extra wrap bit,
// so full/empty come straight from pointer comparison. Head data is read
// combinationally; a push into an empty FIFO is only visible the next cycle.
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted push / pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue + launch sequencer in front of the UART transmitter.
// Optional build macro: UART_TX_FEEDER_STATS_EN adds a sent_count output and a
// launch trace message in simulation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter; pops head
// LAUNCH    | uart_start high this cycle; timeout counter loaded
// WAIT_RISE | waiting for busy to rise; gives up after BUSY_TIMEOUT cycles
// WAIT_FALL | transmitter busy; next launch allowed once it drops
//
// BUSY_TIMEOUT must be >= 2: the counter is loaded with BUSY_TIMEOUT-1 when
// leaving LAUNCH, so the timeout lands exactly BUSY_TIMEOUT cycles after the
// start pulse.
module uart_tx_feeder
   import uart_tx_pkg::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   uart_tx_feeder_if.slave        bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   idle,
   output logic                   err_timeout
`ifdef UART_TX_FEEDER_STATS_EN
   ,
   output logic [31:0]            sent_count
`endif
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   feeder_state_t          state_q, state_d;
   logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic [UART_BYTE_W-1:0] uart_data_q, uart_data_d;
   logic                   uart_start_q, uart_start_d;
   logic                   err_timeout_q, err_timeout_d;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [UART_BYTE_W-1:0] fifo_rd_data;

   byte_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_BYTE_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (bus.in_valid),
      .wr_data (bus.in_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign bus.in_ready   = ~fifo_full;
   assign bus.uart_start = uart_start_q;
   assign bus.uart_data  = uart_data_q;
   assign err_timeout    = err_timeout_q;
   assign idle           = fifo_empty && (state_q == IDLE);

   // Launch sequencing: next state, pop, data capture, timeout down-counter.
   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = tmo_cnt_q;
      uart_data_d   = uart_data_q;
      err_timeout_d = err_timeout_q;
      fifo_pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !bus.uart_busy) begin
               fifo_pop    = 1'b1;
               uart_data_d = fifo_rd_data;
               state_d     = LAUNCH;
            end
         end
         LAUNCH: begin
            tmo_cnt_d = TW'(BUSY_TIMEOUT - 1);
            state_d   = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (bus.uart_busy) begin
               state_d = WAIT_FALL;
            end else if (tmo_cnt_q <= TW'(1)) begin
               // Byte is dropped as consumed; flag stays until reset.
               err_timeout_d = 1'b1;
               state_d       = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TW'(1);
            end
         end
         WAIT_FALL: begin
            if (!bus.uart_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Start is registered so it is glitch-free and coincides with LAUNCH.
      uart_start_d = (state_d == LAUNCH);
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         tmo_cnt_q     <= '0;
         uart_data_q   <= '0;
         uart_start_q  <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         uart_data_q   <= uart_data_d;
         uart_start_q  <= uart_start_d;
         err_timeout_q <= err_timeout_d;
      end
   end

`ifdef UART_TX_FEEDER_STATS_EN
   logic [31:0] sent_count_q, sent_count_d;

   assign sent_count = sent_count_q;

   // Launch counter, wraps naturally.
   always_comb begin
      sent_count_d = sent_count_q;
      if (state_q == LAUNCH) sent_count_d = sent_count_q + 32'd1;
   end

   // Launch counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sent_count_q <= '0;
      else        sent_count_q <= sent_count_d;
   end

`ifndef SYNTHESIS
   // Launch trace for simulation logs.
   always @(posedge clk) begin
      if (rst_n && state_q == LAUNCH) $display("[uart feeder] launch 0x%x", uart_data_q);
   end
`endif
`endif

endmodule
